// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: the tracking-queue entry, the FSM states
// and the instruction size used to form fall-through addresses.
package branch_resolve_unit_pkg;

  localparam logic [31:0] INST_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] inst_addr;
    logic        predict;
    logic [31:0] predict_addr;
  } entry_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute/predictor-update bundle for branch_resolve_unit.
// Statistics outputs exist only when BRANCH_RESOLVE_STAT_EN is defined.
interface branch_resolve_unit_if;

  logic        iFLUSH;
  logic        iPUSH_STB;
  logic [31:0] iPUSH_INST_ADDR;
  logic        iPUSH_PREDICT;
  logic [31:0] iPUSH_PREDICT_ADDR;
  logic        oPUSH_FULL;
  logic        iEXE_STB;
  logic [31:0] iEXE_INST_ADDR;
  logic        iEXE_BRANCH;
  logic        iEXE_JUMP;
  logic [31:0] iEXE_ADDR;
  logic        oJUMP_STB;
  logic        oJUMP_PREDICT;
  logic        oJUMP_HIT;
  logic        oJUMP_JUMP;
  logic [31:0] oJUMP_ADDR;
  logic [31:0] oJUMP_INST_ADDR;
  logic        oREDIRECT_STB;
  logic [31:0] oREDIRECT_ADDR;
  logic        iREDIRECT_ACK;
  logic        oBUSY;
  logic        oERROR;
`ifdef BRANCH_RESOLVE_STAT_EN
  logic [31:0] oSTAT_BRANCH;
  logic [31:0] oSTAT_MISS;

  modport slave (
    input  iFLUSH, iPUSH_STB, iPUSH_INST_ADDR, iPUSH_PREDICT, iPUSH_PREDICT_ADDR,
    input  iEXE_STB, iEXE_INST_ADDR, iEXE_BRANCH, iEXE_JUMP, iEXE_ADDR, iREDIRECT_ACK,
    output oPUSH_FULL, oJUMP_STB, oJUMP_PREDICT, oJUMP_HIT, oJUMP_JUMP, oJUMP_ADDR,
    output oJUMP_INST_ADDR, oREDIRECT_STB, oREDIRECT_ADDR, oBUSY, oERROR,
    output oSTAT_BRANCH, oSTAT_MISS
  );

  modport master (
    output iFLUSH, iPUSH_STB, iPUSH_INST_ADDR, iPUSH_PREDICT, iPUSH_PREDICT_ADDR,
    output iEXE_STB, iEXE_INST_ADDR, iEXE_BRANCH, iEXE_JUMP, iEXE_ADDR, iREDIRECT_ACK,
    input  oPUSH_FULL, oJUMP_STB, oJUMP_PREDICT, oJUMP_HIT, oJUMP_JUMP, oJUMP_ADDR,
    input  oJUMP_INST_ADDR, oREDIRECT_STB, oREDIRECT_ADDR, oBUSY, oERROR,
    input  oSTAT_BRANCH, oSTAT_MISS
  );
`else
  modport slave (
    input  iFLUSH, iPUSH_STB, iPUSH_INST_ADDR, iPUSH_PREDICT, iPUSH_PREDICT_ADDR,
    input  iEXE_STB, iEXE_INST_ADDR, iEXE_BRANCH, iEXE_JUMP, iEXE_ADDR, iREDIRECT_ACK,
    output oPUSH_FULL, oJUMP_STB, oJUMP_PREDICT, oJUMP_HIT, oJUMP_JUMP, oJUMP_ADDR,
    output oJUMP_INST_ADDR, oREDIRECT_STB, oREDIRECT_ADDR, oBUSY, oERROR
  );

  modport master (
    output iFLUSH, iPUSH_STB, iPUSH_INST_ADDR, iPUSH_PREDICT, iPUSH_PREDICT_ADDR,
    output iEXE_STB, iEXE_INST_ADDR, iEXE_BRANCH, iEXE_JUMP, iEXE_ADDR, iREDIRECT_ACK,
    input  oPUSH_FULL, oJUMP_STB, oJUMP_PREDICT, oJUMP_HIT, oJUMP_JUMP, oJUMP_ADDR,
    input  oJUMP_INST_ADDR, oREDIRECT_STB, oREDIRECT_ADDR, oBUSY, oERROR
  );
`endif

endinterface

// File: rtl/branch_resolve_fifo.sv
// In-order tracking queue: synchronous FIFO with wrap-bit pointers, clear input and
// same-cycle push/pop (a pop frees the slot for a push arriving while full).
module branch_resolve_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic   iCLOCK,
  input  logic   iRESET_SYNC,
  input  logic   iCLEAR,
  input  logic   iPUSH,
  input  entry_t iPUSH_DATA,
  input  logic   iPOP,
  output entry_t oHEAD,
  output logic   oFULL,
  output logic   oEMPTY
);

  localparam logic [PTR_W:0] PTR_ONE = 1;

  entry_t           mem_q [DEPTH];
  logic [PTR_W:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W:0]   rdPtr_q, rdPtr_d;
  logic             popEn;
  logic             pushEn;

  assign oEMPTY = (wrPtr_q == rdPtr_q);
  assign oFULL  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                  (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign oHEAD  = mem_q[rdPtr_q[PTR_W-1:0]];

  assign popEn  = iPOP && !oEMPTY;
  assign pushEn = iPUSH && (!oFULL || popEn);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (iCLEAR) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (pushEn) wrPtr_d = wrPtr_q + PTR_ONE;
      if (popEn)  rdPtr_d = rdPtr_q + PTR_ONE;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset; only slots between the pointers are ever read meaningfully.
  always_ff @(posedge iCLOCK) begin
    if (pushEn && !iCLEAR) mem_q[wrPtr_q[PTR_W-1:0]] <= iPUSH_DATA;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves fetch-time predictions against execute outcomes, drives predictor updates and
// mispredict redirects. Define BRANCH_RESOLVE_STAT_EN to build branch/miss counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input logic                  iCLOCK,
  input logic                  iRESET_SYNC,
  branch_resolve_unit_if.slave bus
);

  state_e      state_q, state_d;
  logic        error_q, error_d;
  logic        jumpStb_q, jumpStb_d;
  logic        jumpPredict_q, jumpPredict_d;
  logic        jumpHit_q, jumpHit_d;
  logic        jumpJump_q, jumpJump_d;
  logic [31:0] jumpAddr_q, jumpAddr_d;
  logic [31:0] jumpInstAddr_q, jumpInstAddr_d;
  logic        redirectStb_q, redirectStb_d;
  logic [31:0] redirectAddr_q, redirectAddr_d;

  logic        fifoClear, fifoPush, fifoPop;
  logic        fifoFull, fifoEmpty;
  entry_t      fifoHead, pushEntry;
  logic        exeOk, taken, hit;

  assign pushEntry = '{inst_addr:    bus.iPUSH_INST_ADDR,
                       predict:      bus.iPUSH_PREDICT,
                       predict_addr: bus.iPUSH_PREDICT_ADDR};

  branch_resolve_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) uFifo (
    .iCLOCK     (iCLOCK),
    .iRESET_SYNC(iRESET_SYNC),
    .iCLEAR     (fifoClear),
    .iPUSH      (fifoPush),
    .iPUSH_DATA (pushEntry),
    .iPOP       (fifoPop),
    .oHEAD      (fifoHead),
    .oFULL      (fifoFull),
    .oEMPTY     (fifoEmpty)
  );

  assign exeOk = bus.iEXE_STB && !fifoEmpty && (bus.iEXE_INST_ADDR == fifoHead.inst_addr);
  assign taken = bus.iEXE_BRANCH && bus.iEXE_JUMP;
  assign hit   = (fifoHead.predict == taken) &&
                 (!taken || (fifoHead.predict_addr == bus.iEXE_ADDR));

  always_comb begin
    state_d        = state_q;
    error_d        = error_q;
    jumpStb_d      = 1'b0;
    jumpPredict_d  = jumpPredict_q;
    jumpHit_d      = jumpHit_q;
    jumpJump_d     = jumpJump_q;
    jumpAddr_d     = jumpAddr_q;
    jumpInstAddr_d = jumpInstAddr_q;
    redirectStb_d  = 1'b0;
    redirectAddr_d = redirectAddr_q;
    fifoClear      = 1'b0;
    fifoPush       = 1'b0;
    fifoPop        = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.iFLUSH) begin
          fifoClear = 1'b1;
        end else begin
          if (bus.iEXE_STB && !exeOk) error_d = 1'b1;
          if (bus.iPUSH_STB) begin
            if (fifoFull && !exeOk) error_d  = 1'b1;
            else                    fifoPush = 1'b1;
          end
          if (exeOk) begin
            fifoPop = 1'b1;
            if (bus.iEXE_BRANCH || fifoHead.predict) begin
              jumpStb_d      = 1'b1;
              jumpPredict_d  = fifoHead.predict;
              jumpHit_d      = hit;
              jumpJump_d     = taken;
              jumpAddr_d     = bus.iEXE_ADDR;
              jumpInstAddr_d = fifoHead.inst_addr;
            end
            // Everything queued behind a mispredict is wrong-path, including a same-cycle push.
            if (!hit) begin
              redirectStb_d  = 1'b1;
              redirectAddr_d = taken ? bus.iEXE_ADDR : fifoHead.inst_addr + INST_BYTES;
              fifoClear      = 1'b1;
              state_d        = RECOVER;
            end
          end
        end
      end
      RECOVER: begin
        if (bus.iFLUSH) begin
          fifoClear = 1'b1;
          state_d   = RUN;
        end else if (bus.iREDIRECT_ACK) begin
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q        <= RUN;
      error_q        <= 1'b0;
      jumpStb_q      <= 1'b0;
      jumpPredict_q  <= 1'b0;
      jumpHit_q      <= 1'b0;
      jumpJump_q     <= 1'b0;
      jumpAddr_q     <= '0;
      jumpInstAddr_q <= '0;
      redirectStb_q  <= 1'b0;
      redirectAddr_q <= '0;
    end else begin
      state_q        <= state_d;
      error_q        <= error_d;
      jumpStb_q      <= jumpStb_d;
      jumpPredict_q  <= jumpPredict_d;
      jumpHit_q      <= jumpHit_d;
      jumpJump_q     <= jumpJump_d;
      jumpAddr_q     <= jumpAddr_d;
      jumpInstAddr_q <= jumpInstAddr_d;
      redirectStb_q  <= redirectStb_d;
      redirectAddr_q <= redirectAddr_d;
    end
  end

  assign bus.oPUSH_FULL      = fifoFull;
  assign bus.oJUMP_STB       = jumpStb_q;
  assign bus.oJUMP_PREDICT   = jumpPredict_q;
  assign bus.oJUMP_HIT       = jumpHit_q;
  assign bus.oJUMP_JUMP      = jumpJump_q;
  assign bus.oJUMP_ADDR      = jumpAddr_q;
  assign bus.oJUMP_INST_ADDR = jumpInstAddr_q;
  assign bus.oREDIRECT_STB   = redirectStb_q;
  assign bus.oREDIRECT_ADDR  = redirectAddr_q;
  assign bus.oBUSY           = (state_q == RECOVER);
  assign bus.oERROR          = error_q;

`ifdef BRANCH_RESOLVE_STAT_EN
  logic [31:0] statBranch_q, statMiss_q;

  // Counters saturate rather than wrap so a long run never reports a small count.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      statBranch_q <= '0;
      statMiss_q   <= '0;
    end else begin
      if (jumpStb_d && (statBranch_q != 32'hFFFF_FFFF))   statBranch_q <= statBranch_q + 32'd1;
      if (redirectStb_d && (statMiss_q != 32'hFFFF_FFFF)) statMiss_q   <= statMiss_q + 32'd1;
    end
  end

  assign bus.oSTAT_BRANCH = statBranch_q;
  assign bus.oSTAT_MISS   = statMiss_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   nChecks = 0;
  int   nFails  = 0;

  branch_resolve_unit_if bus ();

  branch_resolve_unit #(.DEPTH(DEPTH)) dut (
    .iCLOCK     (clock),
    .iRESET_SYNC(reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  // stimulus for the next clock edge
  bit          sRst, sFlush, sPush, sPred, sExe, sBr, sJmp, sAck;
  logic [31:0] sPAddr, sPTgt, sEAddr, sETgt;

  // reference model state
  entry_t      mq[$];
  bit          mRecover, mErr, mJStb, mJPred, mJHit, mJJump, mRs;
  logic [31:0] mJAddr, mJInst, mRa, mStatB, mStatM;

  task automatic modelStep();
    entry_t e;
    bit     taken, correct, miss;
    mJStb = 0;
    mRs   = 0;
    if (sRst) begin
      mq.delete();
      mRecover = 0; mErr = 0; mJPred = 0; mJHit = 0; mJJump = 0;
      mJAddr = 0; mJInst = 0; mRa = 0; mStatB = 0; mStatM = 0;
      return;
    end
    if (sFlush) begin
      mq.delete();
      mRecover = 0;
      return;
    end
    if (mRecover) begin
      if (sAck) mRecover = 0;
      return;
    end
    miss = 0;
    if (sExe) begin
      if (mq.size() == 0 || mq[0].inst_addr != sEAddr) begin
        mErr = 1;
      end else begin
        e       = mq.pop_front();
        taken   = sBr && sJmp;
        correct = (e.predict == taken) && (!taken || e.predict_addr == sETgt);
        if (sBr || e.predict) begin
          mJStb = 1; mJPred = e.predict; mJHit = correct; mJJump = taken;
          mJAddr = sETgt; mJInst = e.inst_addr;
          if (mStatB != 32'hFFFF_FFFF) mStatB++;
        end
        if (!correct) begin
          miss = 1;
          mRa  = taken ? sETgt : e.inst_addr + 32'd4;
          if (mStatM != 32'hFFFF_FFFF) mStatM++;
        end
      end
    end
    if (sPush) begin
      if (mq.size() < DEPTH) mq.push_back('{inst_addr: sPAddr, predict: sPred, predict_addr: sPTgt});
      else                   mErr = 1;
    end
    if (miss) begin
      mq.delete();
      mRecover = 1;
      mRs      = 1;
    end
  endtask

  task automatic driveInputs();
    reset                  = sRst;
    bus.iFLUSH             = sFlush;
    bus.iPUSH_STB          = sPush;
    bus.iPUSH_INST_ADDR    = sPAddr;
    bus.iPUSH_PREDICT      = sPred;
    bus.iPUSH_PREDICT_ADDR = sPTgt;
    bus.iEXE_STB           = sExe;
    bus.iEXE_INST_ADDR     = sEAddr;
    bus.iEXE_BRANCH        = sBr;
    bus.iEXE_JUMP          = sJmp;
    bus.iEXE_ADDR          = sETgt;
    bus.iREDIRECT_ACK      = sAck;
  endtask

  task automatic clearStimulus();
    sRst = 0; sFlush = 0; sPush = 0; sPred = 0; sExe = 0; sBr = 0; sJmp = 0; sAck = 0;
    sPAddr = 0; sPTgt = 0; sEAddr = 0; sETgt = 0;
  endtask

  // Drive the staged inputs for one edge, advance the model, then sample #1 later.
  task automatic applyStimulus();
    driveInputs();
    @(posedge clock);
    modelStep();
    #1;
    clearStimulus();
    driveInputs();
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".jumpStb"},      32'(bus.oJUMP_STB),     32'(mJStb));
    checkVal({tag, ".jumpPredict"},  32'(bus.oJUMP_PREDICT), 32'(mJPred));
    checkVal({tag, ".jumpHit"},      32'(bus.oJUMP_HIT),     32'(mJHit));
    checkVal({tag, ".jumpJump"},     32'(bus.oJUMP_JUMP),    32'(mJJump));
    checkVal({tag, ".jumpAddr"},     bus.oJUMP_ADDR,         mJAddr);
    checkVal({tag, ".jumpInstAddr"}, bus.oJUMP_INST_ADDR,    mJInst);
    checkVal({tag, ".redirectStb"},  32'(bus.oREDIRECT_STB), 32'(mRs));
    checkVal({tag, ".redirectAddr"}, bus.oREDIRECT_ADDR,     mRa);
    checkVal({tag, ".busy"},         32'(bus.oBUSY),         32'(mRecover));
    checkVal({tag, ".error"},        32'(bus.oERROR),        32'(mErr));
    checkVal({tag, ".pushFull"},     32'(bus.oPUSH_FULL),    32'(mq.size() == DEPTH));
`ifdef BRANCH_RESOLVE_STAT_EN
    checkVal({tag, ".statBranch"},   bus.oSTAT_BRANCH,       mStatB);
    checkVal({tag, ".statMiss"},     bus.oSTAT_MISS,         mStatM);
`endif
  endtask

  task automatic doPush(input logic [31:0] a, input bit p, input logic [31:0] t);
    sPush = 1; sPAddr = a; sPred = p; sPTgt = t;
  endtask

  task automatic doExe(input logic [31:0] a, input bit br, input bit jmp, input logic [31:0] t);
    sExe = 1; sEAddr = a; sBr = br; sJmp = jmp; sETgt = t;
  endtask

  initial begin
    clearStimulus();
    driveInputs();
    @(posedge clock); #1;

    $display("[TB] reset");
    sRst = 1; applyStimulus(); checkOutput("reset");

    $display("[TB] predicted-taken hit");
    doPush(32'h100, 1, 32'h200); applyStimulus(); checkOutput("t1push");
    doExe(32'h100, 1, 1, 32'h200); applyStimulus(); checkOutput("t1exe");
    checkVal("t1.stb", 32'(bus.oJUMP_STB), 1);
    checkVal("t1.hit", 32'(bus.oJUMP_HIT), 1);
    checkVal("t1.addr", bus.oJUMP_ADDR, 32'h200);
    checkVal("t1.redirect", 32'(bus.oREDIRECT_STB), 0);

    $display("[TB] not-taken predicted, actually taken");
    doPush(32'h104, 0, 32'h0); applyStimulus(); checkOutput("t2push");
    doExe(32'h104, 1, 1, 32'h300); applyStimulus(); checkOutput("t2exe");
    checkVal("t2.hit", 32'(bus.oJUMP_HIT), 0);
    checkVal("t2.redirectStb", 32'(bus.oREDIRECT_STB), 1);
    checkVal("t2.redirectAddr", bus.oREDIRECT_ADDR, 32'h300);
    checkVal("t2.busy", 32'(bus.oBUSY), 1);
    doPush(32'h500, 0, 32'h0); applyStimulus(); checkOutput("t2ignoredPush");
    sAck = 1; applyStimulus(); checkOutput("t2ack");
    checkVal("t2.busyAfterAck", 32'(bus.oBUSY), 0);

    $display("[TB] predicted-taken non-branch, ack with pulse");
    doPush(32'h108, 1, 32'h400); applyStimulus(); checkOutput("t3push");
    doExe(32'h108, 0, 0, 32'h0); applyStimulus(); checkOutput("t3exe");
    checkVal("t3.jump", 32'(bus.oJUMP_JUMP), 0);
    checkVal("t3.redirectAddr", bus.oREDIRECT_ADDR, 32'h10C);
    sAck = 1; applyStimulus(); checkOutput("t3ackPulse");

    $display("[TB] fill to full");
    for (int i = 0; i < DEPTH; i++) begin
      doPush(32'h1000 + 32'(4 * i), 0, 32'h0); applyStimulus();
    end
    checkOutput("fill");
    checkVal("fill.full", 32'(bus.oPUSH_FULL), 1);
    doPush(32'h2000, 0, 32'h0); applyStimulus(); checkOutput("overflow");
    checkVal("overflow.error", 32'(bus.oERROR), 1);
    doPush(32'h2004, 0, 32'h0); doExe(32'h1000, 0, 0, 32'h0); applyStimulus();
    checkOutput("pushPopFull");
    checkVal("pushPopFull.full", 32'(bus.oPUSH_FULL), 1);

    $display("[TB] out-of-order resolve");
    sRst = 1; applyStimulus(); checkOutput("reset2");
    doPush(32'h0, 0, 32'h0); applyStimulus();
    doPush(32'h4, 0, 32'h0); applyStimulus();
    doExe(32'h4, 1, 1, 32'h40); applyStimulus(); checkOutput("badExe");
    checkVal("badExe.error", 32'(bus.oERROR), 1);
    sRst = 1; applyStimulus(); checkOutput("reset3");

    $display("[TB] flush beats execute");
    doPush(32'h80, 1, 32'h90); applyStimulus();
    sFlush = 1; doExe(32'h80, 1, 0, 32'h0); applyStimulus(); checkOutput("flushExe");
    doExe(32'h80, 1, 1, 32'h90); applyStimulus(); checkOutput("afterFlush");

`ifdef BRANCH_RESOLVE_STAT_EN
    $display("[TB] statistics");
    sRst = 1; applyStimulus();
    for (int i = 0; i < 5; i++) begin
      doPush(32'h3000 + 32'(4 * i), 1, 32'h4000); applyStimulus();
      doExe(32'h3000 + 32'(4 * i), 1, 1, (i < 3) ? 32'h4000 : 32'h5000); applyStimulus();
      if (i >= 3) begin sAck = 1; applyStimulus(); end
    end
    checkOutput("stats");
    checkVal("stats.branch", bus.oSTAT_BRANCH, 5);
    checkVal("stats.miss", bus.oSTAT_MISS, 2);
`endif

    $display("[TB] random traffic");
    sRst = 1; applyStimulus();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(63) == 0) sRst = 1;
      if ($urandom_range(31) == 0) sFlush = 1;
      if ($urandom_range(1) == 0)
        doPush(32'($urandom_range(255)) << 2, 1'($urandom_range(1)), 32'($urandom_range(3)) << 4);
      if ($urandom_range(1) == 0) begin
        sExe  = 1;
        sEAddr = (mq.size() > 0 && $urandom_range(7) != 0) ? mq[0].inst_addr
                                                           : 32'($urandom_range(255)) << 2;
        sBr   = 1'($urandom_range(1));
        sJmp  = 1'($urandom_range(1));
        sETgt = (mq.size() > 0 && $urandom_range(3) != 0) ? mq[0].predict_addr
                                                          : 32'($urandom_range(3)) << 4;
      end
      if ($urandom_range(2) == 0) sAck = 1;
      applyStimulus();
      checkOutput("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Execute-side counterpart of the branch predictor. Records each fetch-time prediction in an in-order tracking queue, then compares it against the execute-stage outcome. Generates the predictor update strobe (JUMP_* interface) and a fetch redirect/flush on misprediction. Sits between the fetch stage (push) and the execute/retire stage (resolve), and drives the predictor's update port.

Parameters:
DEPTH, 8, tracking queue entries (power of two, ≥2)
PTR_W, 3, log2(DEPTH); pointers carry one extra wrap bit internally

Ports:
iCLOCK  in  1  clock
iRESET_SYNC  in  1  synchronous active-high reset
iFLUSH  in  1  external pipeline flush; clears queue
iPUSH_STB  in  1  fetch issues one instruction with its prediction
iPUSH_INST_ADDR  in  32  instruction address
iPUSH_PREDICT  in  1  predictor said taken
iPUSH_PREDICT_ADDR  in  32  predicted target
oPUSH_FULL  out  1  queue full; fetch must stall
iEXE_STB  in  1  execute resolves the oldest instruction (in order)
iEXE_INST_ADDR  in  32  resolved instruction address
iEXE_BRANCH  in  1  instruction is a branch
iEXE_JUMP  in  1  branch actually taken
iEXE_ADDR  in  32  actual target
oJUMP_STB  out  1  predictor update strobe
oJUMP_PREDICT  out  1  recorded prediction
oJUMP_HIT  out  1  prediction correct
oJUMP_JUMP  out  1  actual direction
oJUMP_ADDR  out  32  actual target
oJUMP_INST_ADDR  out  32  branch address
oREDIRECT_STB  out  1  mispredict: refetch required
oREDIRECT_ADDR  out  32  refetch address
iREDIRECT_ACK  in  1  fetch has taken the redirect
oBUSY  out  1  in RECOVER state
oERROR  out  1  sticky protocol error

Behaviour:
- Reset (iRESET_SYNC high at an iCLOCK edge): queue empty, state RUN, every output 0. Reset overrides all other inputs, including mid-RECOVER.
- Queue: circular FIFO with read/write pointers of PTR_W+1 bits. Full when the low bits are equal and the wrap bits differ.
  - Push while full: dropped, oERROR set.
  - Push and EXE in the same cycle: both take effect; when full, the pop frees the slot first.
- FSM RUN:
  - Push accepted.
  - iEXE_STB with empty queue or iEXE_INST_ADDR != head address: oERROR set, no pop, no update.
  - Otherwise pop the head. Let P = recorded prediction and T = iEXE_BRANCH && iEXE_JUMP.
    - hit = (P==T) && (!T || PREDICT_ADDR==iEXE_ADDR).
    - Update pulse when iEXE_BRANCH || P: oJUMP_STB=1, PREDICT=P, HIT=hit, JUMP=T, ADDR=iEXE_ADDR, INST_ADDR=head address.
    - Non-branch predicted not-taken: no update.
  - Mispredict (!hit): one-cycle oREDIRECT_STB pulse. oREDIRECT_ADDR = T ? iEXE_ADDR : inst_addr+4 (32-bit wrap). Queue cleared, go to RECOVER.
- FSM RECOVER:
  - oBUSY=1; pushes and EXE strobes ignored (no error).
  - oREDIRECT_ADDR held.
  - iREDIRECT_ACK returns to RUN next cycle; an ACK in the same cycle as the pulse is honoured.
- iFLUSH: clears queue and returns to RUN. It does not cancel an update issued in the same cycle. It has priority over push and EXE in that cycle.
- Latency: all outputs registered; update and redirect appear 1 cycle after iEXE_STB.
- oERROR is cleared only by reset.

Optional Feature:
BRANCH_RESOLVE_STAT_EN
- Defined: adds oSTAT_BRANCH[31:0] (count of update pulses) and oSTAT_MISS[31:0] (count of mispredicts). Both are saturating at 32'hFFFFFFFF and cleared on reset.
- Undefined: the ports are absent and no counters are built.

Decomposition:
- Shared package holds:
  - the queue entry type {inst_addr[31:0], predict, predict_addr[31:0]}
  - FSM encodings (RUN=1'b0, RECOVER=1'b1)
  - the INST_BYTES=4 constant
- One sub-module, branch_resolve_fifo: the synchronous FIFO with clear input, full/empty flags and simultaneous push/pop.

Test Plan:
- Push 0x100 with P=1, target 0x200; EXE 0x100 branch taken to 0x200 → next cycle STB=1, PREDICT=1, HIT=1, JUMP=1, ADDR=0x200, no redirect.
- Push 0x104 with P=0; EXE taken to 0x300 → HIT=0, REDIRECT_STB pulse with ADDR 0x300, oBUSY=1 until ACK, queue empty afterwards.
- Push 0x108 with P=1; EXE as non-branch → JUMP=0, HIT=0, redirect to 0x10C.
- Fill 8 entries → oPUSH_FULL=1. A ninth push sets oERROR. The same cycle with push and EXE keeps occupancy at 8.
- Pushes at 0x0 and 0x4, then EXE with address 0x4 → oERROR=1, no update. Reset clears oERROR and all outputs.
- With BRANCH_RESOLVE_STAT_EN: 3 hits and 2 misses → oSTAT_BRANCH=5, oSTAT_MISS=2.
